wav_src_sched: RTL and testbench

//  Scheduler in front of the I2S DAC FIFO. Selects one of three sample sources:
//  NCO tone, ADC loopback (ADC FIFO read side) or mute. Debounces the four board

---
 rtl/wav_src_sched_pkg.sv | 36 +++
 rtl/key_debounce.sv | 37 +++
 rtl/wav_src_sched.sv | 130 +++++++++++++
 tb/tb_wav_src_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wav_src_sched_pkg.sv
// Shared encodings and helpers for the wave source scheduler.
package wav_src_sched_pkg;

    typedef enum logic [1:0] {
        SRC_TONE = 2'd0,
        SRC_LOOP = 2'd1,
        SRC_MUTE = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_RUN      = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_SWITCH   = 2'd3
    } st_t;

    localparam logic [8:0] GAIN_ONE = 9'd256;
    localparam int         NUM_KEYS = 4;

    // Source rotation order for key[0]: TONE -> LOOP -> MUTE -> TONE.
    function automatic src_t src_next(input src_t s);
        case (s)
            SRC_TONE: return SRC_LOOP;
            SRC_LOOP: return SRC_MUTE;
            default:  return SRC_TONE;
        endcase
    endfunction

    // Unsigned 9-bit gain applied to a signed sample; 256 is unity.
    function automatic logic [15:0] apply_gain(input logic [15:0] s, input logic [8:0] g);
        logic signed [25:0] p;
        p = $signed(s) * $signed({1'b0, g});
        return 16'(p >>> 8);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser and stability counter; emits one pulse per accepted press.
module key_debounce #(
    parameter logic [15:0] DEB_CNT = 16'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic [1:0]  sync;
    logic        lvl;
    logic [15:0] cnt;

    // Level only moves after the synchronised key disagrees with it for DEB_CNT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == DEB_CNT - 16'd1) begin
                lvl   <= sync[1];
                cnt   <= '0;
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/wav_src_sched.sv
// Sample source scheduler: key-driven source/pitch control, click-free gain ramps.
module wav_src_sched
    import wav_src_sched_pkg::*;
#(
    parameter logic [15:0] DEB_CNT   = 16'd1000,
    parameter logic [14:0] ACC_DEF   = 15'h0400,
    parameter logic [14:0] ACC_STEP  = 15'h0040,
    parameter logic [14:0] ACC_MIN   = 15'h0040,
    parameter logic [14:0] ACC_MAX   = 15'h7C00,
    parameter logic [8:0]  FADE_STEP = 9'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_n,
    output logic [14:0] nco_acc,
    input  logic        tone_vld,
    input  logic [15:0] tone_dat,
    input  logic        adc_empty,
    output logic        adc_rd,
    input  logic [15:0] adc_rdat,
    input  logic        dac_full,
    output logic        dac_wr,
    output logic [15:0] dac_wdat,
    output logic [1:0]  src_sel,
    output logic [15:0] drop_cnt
);

    logic [NUM_KEYS-1:0] press;
    // vld_pipe[0]: ADC read issued, data arrives this cycle; vld_pipe[1]: output register valid
    logic [1:0]  vld_pipe;
    logic [8:0]  gain;
    logic        pend;
    st_t         st;
    src_t        src;
    logic        allow, rd_iss, cap_tone, cap_mute, cap, drop;
    logic [15:0] cap_dat, acc_up;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (key_n[i]),
            .press (press[i])
        );
    end

    // A returning ADC read always owns the capture slot so it is never lost.
    assign allow    = !dac_full && !vld_pipe[1];
    assign rd_iss   = (src == SRC_LOOP) && !adc_empty && allow && !vld_pipe[0];
    assign cap_tone = (src == SRC_TONE) && tone_vld && allow && !vld_pipe[0];
    assign cap_mute = (src == SRC_MUTE) && allow && !vld_pipe[0];
    assign cap      = vld_pipe[0] || cap_tone || cap_mute;
    assign cap_dat  = vld_pipe[0] ? adc_rdat : (cap_tone ? tone_dat : 16'd0);
    assign drop     = (src == SRC_TONE) && tone_vld && !cap_tone;
    assign adc_rd   = rd_iss;
    assign dac_wr   = vld_pipe[1];
    assign src_sel  = src;
    assign acc_up   = {1'b0, nco_acc} + {1'b0, ACC_STEP};

    // Pitch register: key[3] restores default, opposing up/down presses cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nco_acc <= ACC_DEF;
        end else if (press[3]) begin
            nco_acc <= ACC_DEF;
        end else if (press[1] && !press[2]) begin
            nco_acc <= (acc_up > {1'b0, ACC_MAX}) ? ACC_MAX : acc_up[14:0];
        end else if (press[2] && !press[1]) begin
            nco_acc <= ({1'b0, nco_acc} < ({1'b0, ACC_MIN} + {1'b0, ACC_STEP})) ?
                       ACC_MIN : nco_acc - ACC_STEP;
        end
    end

    // Capture-to-output stage; gain applied with the value current at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dac_wdat <= '0;
        end else begin
            vld_pipe <= {cap, rd_iss};
            if (cap) dac_wdat <= apply_gain(cap_dat, gain);
        end
    end

    // Fade FSM: gain steps once per captured sample; source changes only at gain 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= ST_FADE_IN;
            gain <= '0;
            src  <= SRC_TONE;
            pend <= 1'b0;
        end else begin
            if (press[0] && !pend) pend <= 1'b1;
            case (st)
                ST_FADE_IN: if (cap) begin
                    if (gain >= GAIN_ONE - FADE_STEP) begin
                        gain <= GAIN_ONE;
                        st   <= ST_RUN;
                    end else begin
                        gain <= gain + FADE_STEP;
                    end
                end
                ST_RUN: begin
                    gain <= GAIN_ONE;
                    if (pend) st <= ST_FADE_OUT;
                end
                ST_FADE_OUT: if (cap) begin
                    if (gain <= FADE_STEP) begin
                        gain <= '0;
                        st   <= ST_SWITCH;
                    end else begin
                        gain <= gain - FADE_STEP;
                    end
                end
                default: begin
                    src  <= src_next(src);
                    pend <= 1'b0;
                    st   <= ST_FADE_IN;
                end
            endcase
        end
    end

    // Saturating count of tone samples that found no free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

endmodule

// File: tb/tb_wav_src_sched.sv
// Self-checking bench for wav_src_sched against a behavioural model.
module tb_wav_src_sched;

    localparam int DEB = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic        tone_vld = 1'b0;
    logic [15:0] tone_dat = '0;
    logic        adc_empty = 1'b1;
    logic [15:0] adc_rdat = '0;
    logic        dac_full = 1'b0;
    logic [14:0] nco_acc;
    logic        adc_rd, dac_wr;
    logic [15:0] dac_wdat, drop_cnt;
    logic [1:0]  src_sel;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_q[$];
    logic [1:0]  ws_q[$];
    int          lrd_cnt = 0;

    wav_src_sched dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .nco_acc(nco_acc),
        .tone_vld(tone_vld), .tone_dat(tone_dat), .adc_empty(adc_empty),
        .adc_rd(adc_rd), .adc_rdat(adc_rdat), .dac_full(dac_full),
        .dac_wr(dac_wr), .dac_wdat(dac_wdat), .src_sel(src_sel), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every DAC write (value and active source) and every loop read.
    always @(negedge clk) begin
        if (dac_wr) begin
            wr_q.push_back(dac_wdat);
            ws_q.push_back(src_sel);
        end
        if (adc_rd && src_sel == 2'd1) lrd_cnt <= lrd_cnt + 1;
    end

    // Expected written value: signed sample times gain, divided by 256 (floor).
    function automatic logic [15:0] gmod(input logic [15:0] s, input int g);
        int p;
        p = $signed(s) * g;
        p = p >>> 8;
        return p[15:0];
    endfunction

    function automatic int ramp(input int k);
        return (4 * k > 256) ? 256 : 4 * k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; key_n = 4'hF; tone_vld = 1'b0; tone_dat = '0;
        dac_full = 1'b0; adc_empty = 1'b1; adc_rdat = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_tone(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tone_vld = 1'b1;
            tick();
            tone_vld = 1'b0;
            repeat (per - 1) tick();
        end
    endtask

    task automatic press_key(input logic [3:0] mask);
        key_n = ~mask;
        repeat (DEB + 10) tick();
        key_n = 4'hF;
        repeat (DEB + 10) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (nco_acc !== 15'h0400) begin errors++; $display("FAIL rst_acc got %h exp 0400", nco_acc); end
        checks++; if (src_sel !== 2'd0) begin errors++; $display("FAIL rst_src got %0d exp 0", src_sel); end
        checks++; if (dac_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got %b exp 0", dac_wr); end
        checks++; if (dac_wdat !== 16'h0) begin errors++; $display("FAIL rst_wdat got %h exp 0", dac_wdat); end
        checks++; if (adc_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %b exp 0", adc_rd); end
        checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
        checks++; if (dut.gain !== 9'd0) begin errors++; $display("FAIL rst_gain got %0d exp 0", dut.gain); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_tone_ramp();
        int base, n;
        do_reset();
        base = wr_q.size();
        tone_dat = 16'h4000;
        drive_tone(80, 8);
        repeat (4) tick();
        n = wr_q.size() - base;
        checks++; if (n !== 80) begin errors++; $display("FAIL ramp_count got %0d exp 80", n); end
        for (int k = 0; k < 80 && base + k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[base + k] !== gmod(16'h4000, ramp(k))) begin
                errors++;
                $display("FAIL ramp_val[%0d] got %h exp %h", k, wr_q[base + k], gmod(16'h4000, ramp(k)));
            end
        end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL ramp_drop got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_pitch();
        int macc, r;
        logic [3:0] m;
        do_reset();
        press_key(4'b0010);
        checks++; if (nco_acc !== 15'h0440) begin errors++; $display("FAIL pitch_up1 got %h exp 0440", nco_acc); end
        press_key(4'b0010);
        checks++; if (nco_acc !== 15'h0480) begin errors++; $display("FAIL pitch_up2 got %h exp 0480", nco_acc); end
        key_n = 4'b1101;
        repeat (100) tick();
        key_n = 4'hF;
        repeat (DEB + 10) tick();
        checks++; if (nco_acc !== 15'h0480) begin errors++; $display("FAIL pitch_glitch got %h exp 0480", nco_acc); end
        macc = 'h480;
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: begin m = 4'b0010; macc = (macc + 'h40 > 'h7C00) ? 'h7C00 : macc + 'h40; end
                1: begin m = 4'b0100; macc = (macc - 'h40 < 'h40) ? 'h40 : macc - 'h40; end
                2: begin m = 4'b1000; macc = 'h400; end
                3: m = 4'b0110;
                default: begin m = 4'b1010; macc = 'h400; end
            endcase
            press_key(m);
            checks++;
            if (nco_acc !== 15'(macc)) begin
                errors++;
                $display("FAIL pitch_rand[%0d] keys %b got %h exp %h", i, m, nco_acc, 15'(macc));
            end
        end
    endtask

    task automatic test_loop();
        int base, lbase, k, lrd;
        logic [15:0] last;
        do_reset();
        base = wr_q.size();
        lbase = lrd_cnt;
        adc_rdat = 16'h1234;
        adc_empty = 1'b0;
        tone_dat = 16'h4000;
        fork
            press_key(4'b0001);
            drive_tone(650, 4);
        join
        adc_empty = 1'b1;
        repeat (10) tick();
        checks++; if (src_sel !== 2'd1) begin errors++; $display("FAIL loop_src got %0d exp 1", src_sel); end
        k = 0;
        last = '0;
        for (int i = base; i < wr_q.size(); i++) begin
            if (ws_q[i] == 2'd1) begin
                if (k < 70) begin
                    checks++;
                    if (wr_q[i] !== gmod(16'h1234, ramp(k))) begin
                        errors++;
                        $display("FAIL loop_val[%0d] got %h exp %h", k, wr_q[i], gmod(16'h1234, ramp(k)));
                    end
                end
                last = wr_q[i];
                k++;
            end
        end
        checks++; if (k < 70) begin errors++; $display("FAIL loop_count got %0d exp >=70", k); end
        checks++; if (last !== 16'h1234) begin errors++; $display("FAIL loop_steady got %h exp 1234", last); end
        lrd = lrd_cnt - lbase;
        checks++; if (lrd !== k) begin errors++; $display("FAIL loop_rd_vs_wr got rd %0d exp wr %0d", lrd, k); end
    endtask

    task automatic test_drop();
        int base, n;
        do_reset();
        base = wr_q.size();
        dac_full = 1'b1;
        tone_dat = 16'h7FFF;
        drive_tone(20, 8);
        repeat (3) tick();
        checks++; if (drop_cnt !== 16'd20) begin errors++; $display("FAIL drop_cnt got %0d exp 20", drop_cnt); end
        n = wr_q.size() - base;
        checks++; if (n !== 0) begin errors++; $display("FAIL drop_nowr got %0d exp 0", n); end
        dac_full = 1'b0;
        drive_tone(1, 8);
        n = wr_q.size() - base;
        checks++; if (n !== 1) begin errors++; $display("FAIL drop_resume got %0d exp 1", n); end
        if (n == 1) begin
            checks++;
            if (wr_q[base] !== 16'h0) begin errors++; $display("FAIL drop_first got %h exp 0", wr_q[base]); end
        end
        checks++; if (drop_cnt !== 16'd20) begin errors++; $display("FAIL drop_hold got %0d exp 20", drop_cnt); end
    endtask

    task automatic test_rand_tone();
        logic [15:0] exp_q[$];
        int base, g, drops, n;
        do_reset();
        base = wr_q.size();
        g = 0;
        drops = 0;
        for (int i = 0; i < 120; i++) begin
            tone_dat = 16'($urandom);
            dac_full = ($urandom_range(0, 3) == 0);
            tone_vld = 1'b1;
            if (!dac_full) begin
                exp_q.push_back(gmod(tone_dat, g));
                g = (g + 4 > 256) ? 256 : g + 4;
            end else begin
                drops++;
            end
            tick();
            tone_vld = 1'b0;
            dac_full = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) tick();
        end
        dac_full = 1'b0;
        repeat (3) tick();
        n = wr_q.size() - base;
        checks++; if (n !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", n, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && base + k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[base + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rand_val[%0d] got %h exp %h", k, wr_q[base + k], exp_q[k]);
            end
        end
        checks++; if (drop_cnt !== 16'(drops)) begin errors++; $display("FAIL rand_drop got %0d exp %0d", drop_cnt, drops); end
    endtask

    task automatic test_single_pending();
        do_reset();
        tone_dat = 16'h4000;
        drive_tone(70, 3);
        press_key(4'b0001);
        checks++; if (src_sel !== 2'd0) begin errors++; $display("FAIL pend_frozen got %0d exp 0", src_sel); end
        press_key(4'b0001);
        press_key(4'b0001);
        drive_tone(80, 3);
        checks++; if (src_sel !== 2'd1) begin errors++; $display("FAIL pend_switch got %0d exp 1", src_sel); end
        adc_rdat = 16'h0100;
        adc_empty = 1'b0;
        repeat (450) tick();
        adc_empty = 1'b1;
        repeat (5) tick();
        checks++; if (src_sel !== 2'd1) begin errors++; $display("FAIL pend_final got %0d exp 1", src_sel); end
    endtask

    task automatic test_rst_mid();
        int base;
        do_reset();
        press_key(4'b0010);
        tone_dat = 16'h4000;
        drive_tone(10, 4);
        tone_vld = 1'b1;
        tick();
        tone_vld = 1'b0;
        checks++; if (dac_wr !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", dac_wr); end
        rst_n = 1'b0;
        #1;
        base = wr_q.size();
        checks++; if (dac_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %b exp 0", dac_wr); end
        checks++; if (dut.gain !== 9'd0) begin errors++; $display("FAIL rstmid_gain got %0d exp 0", dut.gain); end
        checks++; if (nco_acc !== 15'h0400) begin errors++; $display("FAIL rstmid_acc got %h exp 0400", nco_acc); end
        checks++; if (dac_wdat !== 16'h0) begin errors++; $display("FAIL rstmid_wdat got %h exp 0", dac_wdat); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (wr_q.size() !== base) begin errors++; $display("FAIL rstmid_nowr got %0d exp %0d", wr_q.size(), base); end
    endtask

    initial begin
        test_reset();
        test_tone_ramp();
        test_drop();
        test_rand_tone();
        test_pitch();
        test_loop();
        test_single_pending();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
